// File: rtl/obi_arb_pkg.sv
// Shared types for the instruction/data OBI arbiter.
package obi_arb_pkg;

    // Requester identity; also the value stored per in-flight transaction.
    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } obi_src_e;

    // Address-phase lock state: free to arbitrate, or holding a pending request.
    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // The requester that is not s; used to advance the round-robin pointer.
    function automatic obi_src_e other_src(input obi_src_e s);
        return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    endfunction

endpackage

// File: rtl/obi_arb_src_fifo.sv
// In-order queue of 1-bit source IDs, one per transaction granted by memory
// and not yet answered. The head is read combinationally so responses can be
// routed in the same cycle they arrive.
module obi_arb_src_fifo #(
    parameter int  DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head_id,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] id_reg;
    logic [DEPTH-1:0] id_next;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // Per-entry write enable: only the slot under the write pointer takes the new ID.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign id_next[gi] = (push && (wr_ptr_reg == PTR_W'(gi))) ? push_id : id_reg[gi];
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_reg     <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            id_reg <= id_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_id = id_reg[rd_ptr_reg];
    assign count   = count_reg;
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/obi_instr_data_arbiter.sv
// Two-to-one OBI arbiter sharing one memory port between instruction fetch
// and data access. Round-robin selection, address phase held stable while the
// memory stalls, in-order response routing via a source-ID FIFO.
module obi_instr_data_arbiter
    import obi_arb_pkg::*;
#(
    parameter int  MAX_OUTSTANDING = 2,
    parameter int  ADDR_W          = 32,
    parameter int  DATA_W          = 32,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                data_req_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic [CNT_W-1:0]    outstanding_o,
    output logic                proto_err_o
);

    arb_state_e state_reg, state_next;
    obi_src_e   lock_src_reg, lock_src_next;
    obi_src_e   rr_reg, rr_next;
    logic       proto_err_reg, proto_err_next;

    obi_src_e   sel_src;
    logic       sel_req;
    logic       handshake;
    logic       fifo_pop;
    logic       fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    // Source select: a pending locked request wins, otherwise the lone requester, otherwise rr.
    always_comb begin
        sel_src = rr_reg;
        if (state_reg == ARB_LOCKED) begin
            sel_src = lock_src_reg;
        end else if (instr_req_i && !data_req_i) begin
            sel_src = SRC_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            sel_src = SRC_DATA;
        end
        sel_req = (sel_src == SRC_INSTR) ? instr_req_i : data_req_i;
    end

    // A full in-flight window blocks the port; a same-cycle rvalid frees a slot only next cycle.
    assign mem_req_o = sel_req && !fifo_full;
    assign handshake = mem_req_o && mem_gnt_i;

    assign instr_gnt_o = handshake && (sel_src == SRC_INSTR);
    assign data_gnt_o  = handshake && (sel_src == SRC_DATA);

    // Address phase mux: fetches are always full-word reads.
    always_comb begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
        if (sel_src == SRC_INSTR) begin
            mem_addr_o  = instr_addr_i;
            mem_we_o    = 1'b0;
            mem_be_o    = '1;
            mem_wdata_o = '0;
        end
    end

    // Lock, round-robin and error next-state.
    always_comb begin
        state_next     = state_reg;
        lock_src_next  = lock_src_reg;
        rr_next        = rr_reg;
        proto_err_next = proto_err_reg;

        if (state_reg == ARB_LOCKED && !sel_req) begin
            // Requester withdrew a stalled address phase: abandon it and flag the violation.
            state_next     = ARB_FREE;
            proto_err_next = 1'b1;
        end else if (handshake) begin
            state_next = ARB_FREE;
        end else if (mem_req_o) begin
            state_next    = ARB_LOCKED;
            lock_src_next = sel_src;
        end

        if (handshake) begin
            rr_next = other_src(sel_src);
        end

        if (mem_rvalid_i && fifo_empty) begin
            proto_err_next = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ARB_FREE;
            lock_src_reg  <= SRC_INSTR;
            rr_reg        <= SRC_INSTR;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lock_src_reg  <= lock_src_next;
            rr_reg        <= rr_next;
            proto_err_reg <= proto_err_next;
        end
    end

    // Responses with nothing in flight are dropped rather than popped.
    assign fifo_pop = mem_rvalid_i && !fifo_empty;

    obi_arb_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (handshake),
        .push_id (sel_src),
        .pop     (fifo_pop),
        .head_id (fifo_head),
        .count   (outstanding_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign instr_rvalid_o = fifo_pop && (fifo_head == SRC_INSTR);
    assign data_rvalid_o  = fifo_pop && (fifo_head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign proto_err_o    = proto_err_reg;

endmodule

// File: tb/tb_obi_instr_data_arbiter.sv
// Directed bench for obi_instr_data_arbiter: stimulus pushes expected grants
// and responses into queues, a monitor pops and compares them as the DUT
// presents them; cycle-specific checks are made inline.
module tb_obi_instr_data_arbiter;
    import obi_arb_pkg::*;

    localparam int MAX_OUTSTANDING = 2;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [31:0] D_WDATA = 32'hDEADBEEF;
    localparam logic [3:0]  D_BE    = 4'h3;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                instr_req_i = 1'b0;
    logic [ADDR_W-1:0]   instr_addr_i = '0;
    logic                instr_gnt_o, instr_rvalid_o;
    logic [DATA_W-1:0]   instr_rdata_o;
    logic                data_req_i = 1'b0;
    logic [ADDR_W-1:0]   data_addr_i = '0;
    logic                data_we_i = 1'b1;
    logic [DATA_W/8-1:0] data_be_i = D_BE;
    logic [DATA_W-1:0]   data_wdata_i = D_WDATA;
    logic                data_gnt_o, data_rvalid_o;
    logic [DATA_W-1:0]   data_rdata_o;
    logic                mem_req_o, mem_we_o;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic [DATA_W/8-1:0] mem_be_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic                mem_gnt_i = 1'b0;
    logic                mem_rvalid_i = 1'b0;
    logic [DATA_W-1:0]   mem_rdata_i = '0;
    logic [CNT_W-1:0]    outstanding_o;
    logic                proto_err_o;

    obi_instr_data_arbiter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .outstanding_o  (outstanding_o),
        .proto_err_o    (proto_err_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        src;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct packed {
        logic        src;
        logic [31:0] rdata;
    } rsp_t;

    gnt_t exp_gnt_q[$];
    rsp_t exp_rsp_q[$];
    gnt_t mon_g_act, mon_g_exp;
    rsp_t mon_r_act, mon_r_exp;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic g, input logic rv,
                         input logic [31:0] rd);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
    endtask

    task automatic exp_g(input obi_src_e s, input logic [31:0] a);
        gnt_t g;
        g.src   = s;
        g.addr  = a;
        g.we    = (s == SRC_DATA);
        g.be    = (s == SRC_DATA) ? D_BE : 4'hF;
        g.wdata = (s == SRC_DATA) ? D_WDATA : 32'h0;
        exp_gnt_q.push_back(g);
    endtask

    task automatic exp_r(input obi_src_e s, input logic [31:0] d);
        rsp_t r;
        r.src   = s;
        r.rdata = d;
        exp_rsp_q.push_back(r);
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic reset_pulse();
        nxt();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        mid();
        nxt();
        reset = 1'b0;
    endtask

    // Monitor: every grant or response the DUT presents must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (instr_gnt_o && data_gnt_o) begin
                fail_now("both_gnt");
            end else if (instr_gnt_o || data_gnt_o) begin
                if (exp_gnt_q.size() == 0) begin
                    fail_now("gnt_unexpected");
                end else begin
                    mon_g_exp = exp_gnt_q.pop_front();
                    mon_g_act = {data_gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o};
                    chk("gnt_txn", mon_g_act, mon_g_exp);
                    $display("txn gnt src=%0d addr=%08h", mon_g_act.src, mon_g_act.addr);
                end
            end
            if (instr_rvalid_o && data_rvalid_o) begin
                fail_now("both_rvalid");
            end else if (mem_rvalid_i && exp_rsp_q.size() != 0) begin
                mon_r_exp = exp_rsp_q.pop_front();
                if (!(instr_rvalid_o || data_rvalid_o)) begin
                    fail_now("rsp_missing");
                end else begin
                    mon_r_act = {data_rvalid_o, data_rvalid_o ? data_rdata_o : instr_rdata_o};
                    chk("rsp_txn", mon_r_act, mon_r_exp);
                    $display("txn rsp src=%0d rdata=%08h", mon_r_act.src, mon_r_act.rdata);
                end
            end else if (instr_rvalid_o || data_rvalid_o) begin
                fail_now("rsp_unexpected");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        mid();
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
        chk("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
        chk("rst_proto_err", proto_err_o, 0);
        nxt();
        reset = 1'b0;

        // Solo fetch, two wait states
        for (int k = 0; k < 3; k++) begin
            if (k > 0) nxt();
            drive(1, 32'h1A000080, 0, 0, (k == 2), 0, 0);
            if (k == 2) exp_g(SRC_INSTR, 32'h1A000080);
            mid();
            chk("fetch_mem_req", mem_req_o, 1);
            chk("fetch_addr_stable", mem_addr_o, 32'h1A000080);
            chk("fetch_be", mem_be_o, 4'hF);
            chk("fetch_gnt", instr_gnt_o, (k == 2));
        end
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("fetch_outstanding1", outstanding_o, 1);
        chk("fetch_gnt_once", instr_gnt_o, 0);
        nxt(); drive(0, 0, 0, 0, 0, 1, 32'h00000013); exp_r(SRC_INSTR, 32'h00000013); mid();
        chk("fetch_no_data_rvalid", data_rvalid_o, 0);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("fetch_outstanding0", outstanding_o, 0);

        // Contention from a fresh rr pointer: I, D, I, D with 1-cycle responses
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nxt();
            drive((k < 4), 32'h00000100, (k < 4), 32'h00002000, (k < 4), (k > 0), 32'hA0000000 + k);
            if (k < 4) exp_g((k % 2) ? SRC_DATA : SRC_INSTR, (k % 2) ? 32'h00002000 : 32'h00000100);
            if (k > 0) exp_r(((k - 1) % 2) ? SRC_DATA : SRC_INSTR, 32'hA0000000 + k);
            mid();
            chk("cont_outstanding", outstanding_o, (k == 0) ? 0 : 1);
        end
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("cont_outstanding_end", outstanding_o, 0);

        // Lock: data stalled three cycles while instr rises
        for (int k = 0; k < 4; k++) begin
            nxt();
            drive((k >= 1), 32'h00000300, 1, 32'h00001000, (k == 3), 0, 0);
            if (k == 3) exp_g(SRC_DATA, 32'h00001000);
            mid();
            chk("lock_addr_held", mem_addr_o, 32'h00001000);
            chk("lock_we_held", mem_we_o, 1);
            chk("lock_no_instr_gnt", instr_gnt_o, 0);
        end
        nxt(); drive(1, 32'h00000300, 1, 32'h00001000, 1, 0, 0); exp_g(SRC_INSTR, 32'h00000300); mid();
        chk("lock_instr_next", instr_gnt_o, 1);
        nxt(); drive(0, 0, 0, 0, 0, 1, 32'h000000B0); exp_r(SRC_DATA, 32'h000000B0); mid();
        nxt(); drive(0, 0, 0, 0, 0, 1, 32'h000000B1); exp_r(SRC_INSTR, 32'h000000B1); mid();
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("lock_outstanding_end", outstanding_o, 0);

        // Full: two grants, no responses; rr now points at data
        nxt(); drive(1, 32'h00000400, 1, 32'h00002000, 1, 0, 0); exp_g(SRC_DATA, 32'h00002000); mid();
        chk("full_cnt0", outstanding_o, 0);
        nxt(); drive(1, 32'h00000400, 1, 32'h00002000, 1, 0, 0); exp_g(SRC_INSTR, 32'h00000400); mid();
        chk("full_cnt1", outstanding_o, 1);
        nxt(); drive(1, 32'h00000400, 1, 32'h00002000, 1, 0, 0); mid();
        chk("full_cnt2", outstanding_o, 2);
        chk("full_mem_req", mem_req_o, 0);
        chk("full_gnts", {instr_gnt_o, data_gnt_o}, 0);
        nxt(); drive(1, 32'h00000400, 1, 32'h00002000, 1, 1, 32'h000000C0); exp_r(SRC_DATA, 32'h000000C0); mid();
        chk("full_rvalid_mem_req", mem_req_o, 0);
        chk("full_rvalid_gnts", {instr_gnt_o, data_gnt_o}, 0);
        nxt(); drive(1, 32'h00000400, 1, 32'h00002000, 1, 0, 0); exp_g(SRC_DATA, 32'h00002000); mid();
        chk("full_freed_cnt", outstanding_o, 1);
        chk("full_freed_gnt", data_gnt_o, 1);
        nxt(); drive(0, 0, 0, 0, 0, 1, 32'h000000C1); exp_r(SRC_INSTR, 32'h000000C1); mid();
        chk("full_drain_cnt2", outstanding_o, 2);
        nxt(); drive(0, 0, 0, 0, 0, 1, 32'h000000C2); exp_r(SRC_DATA, 32'h000000C2); mid();
        chk("full_drain_cnt1", outstanding_o, 1);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("full_drain_cnt0", outstanding_o, 0);

        // Protocol error: rvalid with nothing in flight
        nxt(); drive(0, 0, 0, 0, 0, 1, 32'h000000EE); mid();
        chk("perr_pre", proto_err_o, 0);
        chk("perr_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("perr_set", proto_err_o, 1);
        chk("perr_cnt", outstanding_o, 0);
        nxt(); mid();
        chk("perr_sticky", proto_err_o, 1);
        reset_pulse();
        mid();
        chk("perr_cleared", proto_err_o, 0);

        // Protocol error: locked instr request withdrawn before grant
        nxt(); drive(1, 32'h00000500, 0, 0, 0, 0, 0); mid();
        chk("drop_req_pending", mem_req_o, 1);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("drop_err_not_yet", proto_err_o, 0);
        chk("drop_mem_req", mem_req_o, 0);
        nxt(); drive(0, 0, 1, 32'h00003000, 1, 0, 0); exp_g(SRC_DATA, 32'h00003000); mid();
        chk("drop_err_set", proto_err_o, 1);
        chk("drop_lock_cleared", data_gnt_o, 1);

        // Reset with two in flight
        nxt(); drive(1, 32'h00000600, 0, 0, 1, 0, 0); exp_g(SRC_INSTR, 32'h00000600); mid();
        chk("rmf_cnt1", outstanding_o, 1);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("rmf_cnt2", outstanding_o, 2);
        nxt();
        reset = 1'b1;
        #1;
        chk("rmf_async_cnt", outstanding_o, 0);
        chk("rmf_async_perr", proto_err_o, 0);
        chk("rmf_async_req", mem_req_o, 0);
        chk("rmf_async_gnts", {instr_gnt_o, data_gnt_o}, 0);
        mid();
        nxt();
        reset = 1'b0;

        // Late response after reset
        nxt(); drive(0, 0, 0, 0, 0, 1, 32'h000000FF); mid();
        chk("late_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        nxt(); drive(0, 0, 0, 0, 0, 0, 0); mid();
        chk("late_perr", proto_err_o, 1);

        chk("gnt_queue_drained", exp_gnt_q.size(), 0);
        chk("rsp_queue_drained", exp_rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
